// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// op encodings, FSM state codes, default width and div-by-zero quotient.
package muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [MD_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Works on magnitudes; sign fix-up happens in the parent.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Carry/borrow needs the extra bit of sum/diff.
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        acc_nxt = acc;
        q_nxt   = q;
        if (is_div) begin
            shifted = {acc, q[WIDTH-1]};
            diff    = shifted - {1'b0, opnd};
            acc_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            sum     = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
            acc_nxt = sum[WIDTH:1];
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning HI/LO.
// IDLE -> RUN (WIDTH iterations) -> FIX (sign fix, HI/LO write).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_r;
    logic             div0_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc     (acc),
        .q       (qreg),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Operand magnitudes for launch; unsigned ops pass through.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod   = {acc, qreg};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -qreg : qreg;
        rem    = neg_r ? -acc : acc;
        if (div0_q) begin
            quo = {WIDTH{DIV0_QUOT[0]}};
        end
        fix_hi = is_div_q ? rem : prod_s[2*WIDTH-1:WIDTH];
        fix_lo = is_div_q ? quo : prod_s[WIDTH-1:0];
    end

    // FSM, iteration state and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0_q   <= 1'b0;
            acc      <= '0;
            qreg     <= '0;
            opnd     <= '0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div0_q   <= op[1] & (b == '0);
                        acc      <= '0;
                        qreg     <= op[1] ? a_mag : b_mag;
                        opnd     <= op[1] ? b_mag : a_mag;
                        count    <= CW'(WIDTH);
                        state    <= S_RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    qreg  <= q_nxt;
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN) || (state == S_FIX);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    // Issue an op (optionally in the current cycle) and wait for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string nm, input bit now, output int bc);
        exp_t e;
        bit seen;
        if (!now) @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e.hi  = eh;
        e.lo  = el;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        bc    = 0;
        seen  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int bc;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7_m3", 1'b0, bc);
        check("mult_busy_cycles", bc, 32'd33);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'h0);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0, bc);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2", 1'b0, bc);
        // Launched in the done cycle of the previous op.
        run_op(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_by0", 1'b1, bc);
        check("done_cycle_start_busy", bc, 32'd33);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf", 1'b0, bc);
        run_op(2'b10, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF, "div_by0_neg", 1'b0, bc);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, "div_7_m2", 1'b0, bc);

        // Mult 3*5 with an ignored start and mthi while busy.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd5;
        begin
            exp_t e;
            e.hi = 32'h0;
            e.lo = 32'd15;
            e.name = "mult_3_5";
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd3;
        hi_we = 1'b1;
        wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("busy_hold_hi", hi, 32'h1);
        check("busy_hold_lo", lo, 32'hFFFFFFFD);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL mult_3_5_timeout actual=no_done required=done");
                void'(sb.pop_front());
            end
        end
        @(negedge clk);
        check("ignored_start_idle", {31'b0, busy}, 32'h0);

        // mtlo in IDLE: write, no done.
        lo_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_hi", hi, 32'h0);
        check("mtlo_no_done", {31'b0, done}, 32'h0);

        // Both strobes together.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5A5A;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthilo_hi", hi, 32'h5A5A);
        check("mthilo_lo", lo, 32'h5A5A);

        // Abort divu 1000/7 with reset.
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd1000;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, "divu_1000_7", 1'b0, bc);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
